pipe_reg_type_d: RTL and testbench

- Parametrised multi-stage D-register pipeline with per-stage valid bits and valid/ready flow control.
- Successor to the single 2-bit D flip-flop: generalised in width and depth; adds stall, bubble collapsing, synchronous flush and occupancy count.
- Sits between datapath blocks, for example the 2-bit multiplexer outputs, to retime data with back-pressure.

---
 rtl/pipe_reg_type_d_pkg.sv | 12 +
 rtl/pipe_reg_type_d_stage.sv | 32 +++
 rtl/pipe_reg_type_d.sv | 85 ++++++++
 tb/tb_pipe_reg_type_d.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_type_d_pkg.sv
// Shared defaults and helpers for the valid/ready D-register pipeline.
package pipe_reg_type_d_pkg;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_DEPTH = 4;

    // Bits needed to represent an occupancy of 0..depth inclusive.
    function automatic int cnt_bits(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_type_d_stage.sv
// One pipeline stage: data register plus valid bit with load/flush control.
module pipe_reg_type_d_stage
    import pipe_reg_type_d_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             flush,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Bubbles only clear the valid bit; the data register keeps its value.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_type_d.sv
// Multi-stage D-register pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and an occupancy count.
module pipe_reg_type_d
    import pipe_reg_type_d_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = cnt_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic                        push;
    logic                        pop;

    // A stage advances if it is empty or everything below it can move.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !v[i] | adv[i+1];
        end
    end

    always_comb begin
        src_v    = '0;
        src_d    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_reg_type_d_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset_L  (reset_L),
            .flush    (flush),
            .load     (adv[i]),
            .src_valid(src_v[i]),
            .src_data (src_d[i]),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign in_ready  = adv[0] & !flush & reset_L;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_reg_type_d.sv
// Directed checks on the default pipeline plus scoreboarded DEPTH=1/7 sweeps.
module tb_pipe_reg_type_d;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0] in_data, out_data;
    logic [2:0] count;

    logic       a_iv, a_ir, a_ov, a_or;
    logic [7:0] a_id, a_od;
    logic [0:0] a_cnt;
    logic       b_iv, b_ir, b_ov, b_or;
    logic [7:0] b_id, b_od;
    logic [2:0] b_cnt;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [1:0] sw[4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_reg_type_d u_dut (
        .clk(clk), .reset_L(reset_L),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    pipe_reg_type_d #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .reset_L(reset_L),
        .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .flush(1'b0),
        .out_valid(a_ov), .out_data(a_od), .out_ready(a_or),
        .count(a_cnt)
    );

    pipe_reg_type_d #(.WIDTH(8), .DEPTH(7)) u_d7 (
        .clk(clk), .reset_L(reset_L),
        .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .flush(1'b0),
        .out_valid(b_ov), .out_data(b_od), .out_ready(b_or),
        .count(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pa, sa, pb, sb;
        sw = '{2'd1, 2'd2, 2'd0, 2'd2};
        reset_L = 1'b1;
        in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        a_iv = 1'b0; a_id = '0; a_or = 1'b0;
        b_iv = 1'b0; b_id = '0; b_or = 1'b0;

        #1 reset_L = 1'b0;
        #1;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", 32'(out_data), 0);
        chk("rst_cnt", 32'(count), 0);
        chk("rst_ir", 32'(in_ready), 0);
        tick();
        tick();
        reset_L = 1'b1;
        #1;
        chk("rel_ir", 32'(in_ready), 1);

        // reset in the middle of a stream
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data = 2'(j + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("fill_cnt", 32'(count), 3);
        #1 reset_L = 1'b0;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 0);
        chk("mid_rst_od", 32'(out_data), 0);
        chk("mid_rst_cnt", 32'(count), 0);
        tick();
        reset_L = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data = 2'b01;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("lat_early_ov", 32'(out_valid), 0);
        tick();
        chk("lat_ov", 32'(out_valid), 1);
        chk("lat_od", 32'(out_data), 1);
        chk("lat_cnt", 32'(count), 1);
        tick();
        chk("lat_pop_cnt", 32'(count), 0);
        chk("lat_pop_ov", 32'(out_valid), 0);

        // streaming at full rate
        for (int j = 0; j < 12; j++) begin
            in_valid = 1'b1;
            in_data = 2'(j);
            tick();
            if (j >= 3) begin
                chk("str_ov", 32'(out_valid), 1);
                chk("str_od", 32'(out_data), (j - 3) & 3);
                chk("str_cnt", 32'(count), 4);
                chk("str_ir", 32'(in_ready), 1);
            end
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("str_end_cnt", 32'(count), 0);
        chk("str_end_ov", 32'(out_valid), 0);

        // full stall
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data = sw[j];
            tick();
        end
        in_data = 2'd3;
        #1;
        chk("stall_ir", 32'(in_ready), 0);
        chk("stall_cnt", 32'(count), 4);
        chk("stall_od", 32'(out_data), 1);
        tick();
        tick();
        chk("stall_hold_cnt", 32'(count), 4);
        chk("stall_hold_od", 32'(out_data), 1);
        chk("stall_hold_ov", 32'(out_valid), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("stall_rel_ir", 32'(in_ready), 1);
        for (int j = 1; j < 4; j++) begin
            tick();
            chk("drain_od", 32'(out_data), 32'(sw[j]));
            chk("drain_cnt", 32'(count), 4 - j);
        end
        tick();
        chk("drain_end_ov", 32'(out_valid), 0);
        chk("drain_end_cnt", 32'(count), 0);

        // bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 2'b10;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data = 2'b11;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("bub_cnt", 32'(count), 2);
        chk("bub_ov", 32'(out_valid), 1);
        chk("bub_od", 32'(out_data), 2);
        chk("bub_ir", 32'(in_ready), 1);
        out_ready = 1'b1;
        tick();
        chk("bub_2nd_ov", 32'(out_valid), 1);
        chk("bub_2nd_od", 32'(out_data), 3);
        chk("bub_2nd_cnt", 32'(count), 1);
        tick();
        chk("bub_end_ov", 32'(out_valid), 0);
        chk("bub_end_cnt", 32'(count), 0);

        // flush with simultaneous push and pop
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data = 2'(j + 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("fl_pre_cnt", 32'(count), 3);
        chk("fl_pre_od", 32'(out_data), 1);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 2'd2;
        out_ready = 1'b1;
        #1;
        chk("fl_ir", 32'(in_ready), 0);
        chk("fl_ov", 32'(out_valid), 1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_cnt", 32'(count), 0);
        chk("fl_post_ov", 32'(out_valid), 0);
        repeat (4) tick();
        chk("fl_late_ov", 32'(out_valid), 0);
        chk("fl_late_cnt", 32'(count), 0);

        // random sweep on DEPTH=1 and DEPTH=7
        tick();
        for (int c = 0; c < 460; c++) begin
            if (c < 400) begin
                a_iv = 1'($urandom_range(0, 1));
                a_or = 1'($urandom_range(0, 1));
                b_iv = ($urandom_range(0, 3) != 0);
                b_or = ($urandom_range(0, 2) != 0);
            end else begin
                a_iv = 1'b0; a_or = 1'b1;
                b_iv = 1'b0; b_or = 1'b1;
            end
            a_id = 8'($urandom);
            b_id = 8'($urandom);
            #1;
            chk("d1_cnt", 32'(a_cnt), qa.size());
            chk("d1_ov_empty", 32'(a_ov && qa.size() == 0), 0);
            if (a_ov && qa.size() != 0)
                chk("d1_data", 32'(a_od), 32'(qa[0]));
            chk("d7_cnt", 32'(b_cnt), qb.size());
            chk("d7_ov_empty", 32'(b_ov && qb.size() == 0), 0);
            if (b_ov && qb.size() != 0)
                chk("d7_data", 32'(b_od), 32'(qb[0]));
            pa = a_ov & a_or;
            sa = a_iv & a_ir;
            pb = b_ov & b_or;
            sb = b_iv & b_ir;
            @(posedge clk);
            if (pa && qa.size() != 0) void'(qa.pop_front());
            if (sa) qa.push_back(a_id);
            if (pb && qb.size() != 0) void'(qb.pop_front());
            if (sb) qb.push_back(b_id);
            #1;
        end
        chk("d1_drained", 32'(a_cnt), 0);
        chk("d7_drained", 32'(b_cnt), 0);
        chk("d7_q_empty", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
